// File: rtl/ov5640_cfg_sequencer_pkg.sv
// Shared definitions for the OV5640 register-table sequencer.
// Holds the FSM encoding and the special register-address markers.
package ov5640_cfg_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ROMWAIT,
    ST_DECODE,
    ST_WRITE,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] DELAY_MARK = 16'hFFFF;
  localparam logic [15:0] END_MARK   = 16'hFFFE;

endpackage

// File: rtl/ov5640_cfg_sequencer_delay_timer.sv
// Millisecond down-counter for delay entries: load ms*TICKS_PER_MS, count while
// enabled, and expire once the final cycle of the wait is reached.
module cfg_delay_timer #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_ms,
  input  logic       i_count,
  output logic       o_expire
);

  logic [31:0] r_cnt;
  logic [31:0] w_load;

  assign w_load = 32'(i_ms) * 32'(TICKS_PER_MS);

  always_ff @(posedge clk) begin
    if (reset)                         r_cnt <= '0;
    else if (i_load)                   r_cnt <= w_load;
    else if (i_count && r_cnt != '0)   r_cnt <= r_cnt - 32'd1;
  end

  // A load of N gives exactly N counting cycles; a load of 0 behaves like 1.
  assign o_expire = (r_cnt <= 32'd1);

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Walks an external register table ({addr16, data8} entries) per profile and
// issues SCCB writes, millisecond delays and retries until an end marker.
module ov5640_cfg_sequencer
  import ov5640_cfg_sequencer_pkg::*;
#(
  parameter int INDEX_WIDTH  = 8,
  parameter int PROFILE_BITS = 1,
  parameter int TICKS_PER_MS = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [PROFILE_BITS-1:0]           profile_sel,
  output logic [PROFILE_BITS+INDEX_WIDTH-1:0] rom_addr,
  input  logic [23:0]                       rom_q,
  output logic                              wr_req,
  output logic [15:0]                       wr_addr,
  output logic [7:0]                        wr_data,
  input  logic                              wr_ack,
  input  logic                              wr_nack,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [INDEX_WIDTH-1:0]            fail_index
);

  state_t                    r_state, w_next;
  logic [PROFILE_BITS-1:0]   r_profile;
  logic [INDEX_WIDTH-1:0]    r_index;
  logic [7:0]                r_retry;
  logic [15:0]               r_wr_addr;
  logic [7:0]                r_wr_data;
  logic [INDEX_WIDTH-1:0]    r_fail_index;

  logic w_start_ok, w_last, w_is_end, w_is_delay, w_retry_max, w_expire;

  assign w_start_ok  = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign w_last      = (r_index == {INDEX_WIDTH{1'b1}});
  assign w_is_end    = (rom_q[23:8] == END_MARK);
  assign w_is_delay  = (rom_q[23:8] == DELAY_MARK);
  assign w_retry_max = (r_retry == 8'(MAX_RETRY));

  cfg_delay_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == ST_DECODE && w_is_delay),
    .i_ms     (rom_q[7:0]),
    .i_count  (r_state == ST_DELAY),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // A NACK re-enters DECODE: rom_addr is unchanged so rom_q still holds the
  // same entry, and the DECODE cycle doubles as the one-cycle request gap.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_ROMWAIT;
      ST_ROMWAIT: w_next = ST_DECODE;
      ST_DECODE: begin
        if (w_is_end)        w_next = ST_DONE;
        else if (w_is_delay) w_next = ST_DELAY;
        else                 w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_nack)     w_next = w_retry_max ? ST_ERR : ST_DECODE;
        else if (wr_ack) w_next = ST_NEXT;
      end
      ST_DELAY: if (w_expire) w_next = ST_NEXT;
      ST_NEXT:  w_next = w_last ? ST_DONE : ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_req = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    error  = 1'b0;
    unique case (r_state)
      ST_WRITE: begin wr_req = 1'b1; busy = 1'b1; end
      ST_FETCH, ST_ROMWAIT, ST_DECODE, ST_DELAY, ST_NEXT: busy = 1'b1;
      ST_DONE:  done  = 1'b1;
      ST_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_profile    <= '0;
      r_index      <= '0;
      r_retry      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_fail_index <= '0;
    end else begin
      if (w_start_ok) begin
        r_profile    <= profile_sel;
        r_index      <= '0;
        r_retry      <= '0;
        r_fail_index <= '0;
      end
      if (r_state == ST_NEXT) begin
        r_retry <= '0;
        if (!w_last) r_index <= r_index + 1'b1;
      end
      if (r_state == ST_DECODE && !w_is_end && !w_is_delay) begin
        r_wr_addr <= rom_q[23:8];
        r_wr_data <= rom_q[7:0];
      end
      if (r_state == ST_WRITE && wr_nack) begin
        if (w_retry_max) r_fail_index <= r_index;
        else             r_retry      <= r_retry + 8'd1;
      end
    end
  end

  assign rom_addr   = {r_profile, r_index};
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign fail_index = r_fail_index;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Directed bench: table ROM model, auto ACK/NACK responder and request log,
// with hand-computed expectations per scenario.
module tb_ov5640_cfg_sequencer;

  localparam int TPM = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [0:0]  profile_sel = 1'b0;
  logic [8:0]  rom_addr;
  logic [23:0] rom_q = '0;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, wr_nack;
  logic        busy, done, error;
  logic [7:0]  fail_index;

  ov5640_cfg_sequencer #(
    .INDEX_WIDTH(8), .PROFILE_BITS(1), .TICKS_PER_MS(TPM), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .profile_sel(profile_sel),
    .rom_addr(rom_addr), .rom_q(rom_q), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_nack(wr_nack), .busy(busy),
    .done(done), .error(error), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:511];
  always @(posedge clk) rom_q <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // responder state
  int          resp_delay = 0, nack_left = 0, hi_cnt = 0, viol = 0, bad_msb = 0;
  logic [15:0] nack_addr = 16'h0;
  logic        exp_msb = 1'b0, msb_chk = 1'b0, force_ack = 1'b0;
  logic        resp_prev = 1'b0, req_prev = 1'b0;
  logic [23:0] req_log[$];
  int          req_cyc[$];
  int          ack_cyc[$];

  initial begin
    wr_ack = 1'b0; wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req && resp_prev) viol++;
      if (wr_req && !req_prev) begin
        req_log.push_back({wr_addr, wr_data});
        req_cyc.push_back(cyc);
      end
      if (msb_chk && busy && rom_addr[8] != exp_msb) bad_msb++;
      req_prev  = wr_req;
      resp_prev = 1'b0;
      wr_ack    = force_ack;
      wr_nack   = 1'b0;
      if (wr_req) begin
        hi_cnt++;
        if (hi_cnt > resp_delay) begin
          resp_prev = 1'b1;
          hi_cnt    = 0;
          if (wr_addr == nack_addr && nack_left != 0) begin
            wr_nack = 1'b1;
            if (nack_left > 0) nack_left--;
          end else begin
            wr_ack = 1'b1;
            ack_cyc.push_back(cyc);
          end
        end
      end else hi_cnt = 0;
    end
  end

  function automatic logic [23:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 24'h0;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < req_cyc.size()) ? req_cyc[i] : 0;
  endfunction

  function automatic int count_addr(input logic [15:0] a);
    int n = 0;
    foreach (req_log[i]) if (req_log[i][23:8] == a) n++;
    return n;
  endfunction

  task automatic clear_log();
    req_log.delete(); req_cyc.delete(); ack_cyc.delete();
  endtask

  task automatic do_start(input logic p);
    @(negedge clk); profile_sel = p; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(done || error) && n < max) begin @(negedge clk); n++; end
    if (!(done || error)) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 24'hFFFE00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_fail_index", fail_index, 0);
    reset = 1'b0;

    // basic table with a 5 ms delay
    mem[0] = 24'h310311; mem[1] = 24'h300882; mem[2] = 24'hFFFF05;
    mem[3] = 24'h300842; mem[4] = 24'hFFFE00;
    clear_log(); resp_delay = 1;
    do_start(1'b0);
    wait_end(1000);
    chk("t2_nreq", req_log.size(), 3);
    chk("t2_req0", req_at(0), 24'h310311);
    chk("t2_req1", req_at(1), 24'h300882);
    chk("t2_req2", req_at(2), 24'h300842);
    chk("t2_delay_ok", (ack_cyc.size() >= 2 && cyc_at(2) - ack_cyc[1] >= 5 * TPM), 1);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_error", error, 0);

    // two NACKs then ACK on entry 2, profile 1
    mem[256] = 24'h2000A0; mem[257] = 24'h2001A1; mem[258] = 24'h2002A2;
    mem[259] = 24'h2003A3; mem[260] = 24'hFFFE00;
    clear_log(); resp_delay = 0; nack_addr = 16'h2002; nack_left = 2;
    exp_msb = 1'b1; msb_chk = 1'b1;
    do_start(1'b1);
    wait_end(1000);
    chk("t3_nreq", req_log.size(), 6);
    chk("t3_e2_reqs", count_addr(16'h2002), 3);
    chk("t3_gap1", cyc_at(3) - cyc_at(2), 2);
    chk("t3_gap2", cyc_at(4) - cyc_at(3), 2);
    chk("t3_last", req_at(5), 24'h2003A3);
    chk("t3_done", done, 1);
    chk("t3_error", error, 0);

    // restart from DONE, with ignored start pulses while busy
    clear_log(); nack_left = 0;
    do_start(1'b1);
    repeat (2) @(negedge clk);
    do_start(1'b0);
    repeat (4) @(negedge clk);
    do_start(1'b0);
    wait_end(1000);
    chk("t4_nreq", req_log.size(), 4);
    chk("t4_first", req_at(0), 24'h2000A0);
    chk("t4_last", req_at(3), 24'h2003A3);
    chk("t4_msb", bad_msb, 0);
    chk("t4_done", done, 1);
    msb_chk = 1'b0;

    // persistent NACK at index 5
    for (int i = 0; i < 10; i++) mem[i] = {16'h1000 + 16'(i), 8'(i)};
    mem[10] = 24'hFFFE00;
    clear_log(); resp_delay = 2; nack_addr = 16'h1005; nack_left = -1;
    do_start(1'b0);
    wait_end(1000);
    chk("t5_nreq", req_log.size(), 9);
    chk("t5_e5_reqs", count_addr(16'h1005), 4);
    chk("t5_no_e6", count_addr(16'h1006), 0);
    chk("t5_error", error, 1);
    chk("t5_done", done, 0);
    chk("t5_fail_index", fail_index, 5);
    chk("t5_busy", busy, 0);
    chk("t5_gap_viol", viol, 0);

    // reset during an outstanding write, then a stray ack in IDLE
    clear_log(); nack_left = 0; resp_delay = 1000;
    do_start(1'b0);
    begin
      int n = 0;
      while (!wr_req && n < 50) begin @(negedge clk); n++; end
    end
    chk("t6_wr_req_seen", wr_req, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_wr_req", wr_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rom_addr", rom_addr, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_flags", {done, error}, 0);
    chk("t6_fail_index", fail_index, 0);
    reset = 1'b0;
    clear_log();
    @(posedge clk); force_ack = 1'b1;
    @(posedge clk); force_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_stray_busy", busy, 0);
    chk("t6_stray_flags", {done, error, wr_req}, 0);
    chk("t6_stray_nreq", req_log.size(), 0);
    resp_delay = 0;
    do_start(1'b0);
    wait_end(1000);
    chk("t6_restart_first", req_at(0), 24'h100000);
    chk("t6_restart_nreq", req_log.size(), 10);
    chk("t6_restart_done", done, 1);

    // full profile without end marker
    for (int i = 0; i < 256; i++) mem[256 + i] = {16'h4000 + 16'(i), 8'(i)};
    clear_log(); viol = 0; bad_msb = 0; exp_msb = 1'b1; msb_chk = 1'b1;
    do_start(1'b1);
    wait_end(4000);
    repeat (20) @(negedge clk);
    chk("t7_nreq", req_log.size(), 256);
    chk("t7_first", req_at(0), 24'h400000);
    chk("t7_last", req_at(255), 24'h40FFFF);
    chk("t7_done", done, 1);
    chk("t7_no_wrap", rom_addr, 9'h1FF);
    chk("t7_msb", bad_msb, 0);
    chk("t7_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ov5640_cfg_sequencer.md
OV5640_CFG_SEQUENCER -- requirements
Module: ov5640_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter INDEX_WIDTH, default 8, meaning the entry index width per profile.
REQ-002 The block SHALL have parameter PROFILE_BITS, default 1, meaning the profile-select width; 2**PROFILE_BITS profiles are available.
REQ-003 The block SHALL have parameter TICKS_PER_MS, default 50000, meaning clk cycles per millisecond.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, meaning the number of re-attempts after a NACK before an error.
REQ-005 Ports, listed as name, direction, width, meaning:
- clk, in, 1, the single clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse that begins a sequence.
- profile_sel, in, PROFILE_BITS, the table profile, sampled on start.
- rom_addr, out, PROFILE_BITS+INDEX_WIDTH, table address {profile, index}.
- rom_q, in, 24, table entry {reg_addr[15:0], reg_data[7:0]}, valid 1 cycle after rom_addr.
- wr_req, out, 1, SCCB write request.
- wr_addr, out, 16, SCCB register address.
- wr_data, out, 8, SCCB register data.
- wr_ack, in, 1, pulse: write completed.
- wr_nack, in, 1, pulse: write failed.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence finished; level until the next start or reset.
- error, out, 1, sequence aborted; level until the next start or reset.
- fail_index, out, INDEX_WIDTH, index of the failing entry.

Function
REQ-006 Entry decode SHALL be: reg_addr 16'hFFFF is a delay entry of reg_data milliseconds; reg_addr 16'hFFFE is the end marker; any other value is a register write.
REQ-007 The FSM states SHALL be IDLE, FETCH, ROMWAIT, DECODE, WRITE, DELAY, NEXT, DONE, ERR.
REQ-008 A start in IDLE, DONE or ERR SHALL latch profile_sel, set index=0, clear done/error/fail_index, and enter FETCH; a start in any other state SHALL be ignored.
REQ-009 FETCH SHALL drive rom_addr={profile, index}; ROMWAIT SHALL absorb the 1-cycle ROM latency; DECODE SHALL register rom_q.
REQ-010 The block SHALL assert wr_req in WRITE, with wr_addr/wr_data stable, until the cycle wr_ack or wr_nack is seen; wr_req SHALL be low in the following cycle.
REQ-011 If wr_ack and wr_nack are asserted in the same cycle, wr_nack SHALL take priority.
REQ-012 On NACK with retry_cnt<MAX_RETRY, the block SHALL increment retry_cnt, hold wr_req low for exactly one cycle, then re-request the same entry.
REQ-013 On NACK with retry_cnt==MAX_RETRY, the block SHALL enter ERR, set error=1 and fail_index=index.
REQ-014 retry_cnt SHALL clear on every new entry.
REQ-015 DELAY SHALL wait exactly reg_data*TICKS_PER_MS cycles, using a 32-bit counter; reg_data=0 SHALL advance the following cycle.
REQ-016 NEXT SHALL increment index and return to FETCH.
REQ-017 If the index equal to 2**INDEX_WIDTH-1 completes without an end marker, the block SHALL enter DONE and SHALL NOT wrap.
REQ-018 busy SHALL be 1 in FETCH through NEXT and 0 in IDLE, DONE and ERR.
REQ-019 When not in WRITE, wr_req SHALL be 0 and wr_addr/wr_data SHALL hold their last values.
REQ-020 The end marker SHALL produce no write and go directly to DONE.
REQ-021 A stray wr_ack or wr_nack outside WRITE SHALL be ignored.

Reset
REQ-022 On reset the state SHALL be IDLE and all outputs 0: rom_addr, wr_req, wr_addr, wr_data, busy, done, error, fail_index.
REQ-023 Reset mid-write or mid-delay SHALL abort immediately with no further wr_req; the next start SHALL restart at index 0.

Structure
REQ-024 The shared package SHALL hold the state encoding and the constants DELAY_MARK=16'hFFFF and END_MARK=16'hFFFE.
REQ-025 The block SHALL contain one sub-module, cfg_delay_timer: a millisecond timer with load/count/expire for the DELAY state.
REQ-026 The table ROM SHALL be external, with 1-cycle registered latency.

Verification
REQ-027 Profile 0 with table {3103_11, 3008_82, FFFF_05, 3008_42, FFFE_00}, always ACK -> exactly 3 writes in order; the 3008_42 wr_req rises at least 5*TICKS_PER_MS cycles after the 3008_82 ack; then done=1 and busy=0.
REQ-028 NACK twice on entry 2, then ACK, with MAX_RETRY=3 -> entry 2 is requested 3 times with a 1-cycle gap between requests; done=1 and error=0.
REQ-029 Always NACK on index 5 -> 4 requests, then error=1, fail_index=5, and no request for index 6.
REQ-030 Start with profile_sel=1 -> rom_addr MSB=1 throughout; start pulses during busy change nothing; a start in DONE reruns from index 0.
REQ-031 Reset asserted while wr_req=1 -> wr_req=0 the next cycle and all outputs 0; a stray wr_ack in IDLE has no effect.
REQ-032 A full 256-entry profile with no end marker -> 256 writes, then done and no wrap to index 0.
